// File: rtl/lgn_frame_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | lgn_frame_streamer                                                       |
// | Streams one binarised image into the LGN MNIST core byte by byte and     |
// | captures the class index/score once the core has settled.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lgn_frame_streamer #(
    parameter int BYTES_PER_FRAME = 98,
    parameter int SETTLE_CYCLES   = 16,
    parameter int INDEX_W         = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               abort,
    output logic [7:0]         core_ui,
    output logic               core_load,
    input  logic [INDEX_W-1:0] core_index,
    input  logic [7:0]         core_value,
    output logic [INDEX_W-1:0] res_index,
    output logic [7:0]         res_value,
    output logic               res_valid,
    output logic               busy
);

    localparam int c_BYTE_W   = $clog2(BYTES_PER_FRAME + 1);
    localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [c_BYTE_W-1:0]   c_LAST_BYTE   = c_BYTE_W'(BYTES_PER_FRAME - 1);
    localparam logic [c_SETTLE_W-1:0] c_LAST_SETTLE = c_SETTLE_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_STREAM  = 2'd1;
    localparam logic [1:0] c_ST_SETTLE  = 2'd2;
    localparam logic [1:0] c_ST_CAPTURE = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_BYTE_W-1:0]   r_byte_cnt;
    logic [c_BYTE_W-1:0]   w_byte_cnt_nxt;
    logic [c_SETTLE_W-1:0] r_settle_cnt;
    logic [c_SETTLE_W-1:0] w_settle_cnt_nxt;
    logic                  w_accept;
    logic                  w_capture;

    logic [7:0]            r_core_ui;
    logic                  r_core_load;
    logic [INDEX_W-1:0]    r_res_index;
    logic [7:0]            r_res_value;
    logic                  r_res_valid;

    // abort gates s_ready so a byte presented alongside it is dropped
    assign s_ready  = ((r_state == c_ST_IDLE) || (r_state == c_ST_STREAM)) && !abort;
    assign w_accept = s_valid && s_ready;
    assign busy     = (r_state != c_ST_IDLE);

    always_comb begin
        w_state_nxt      = r_state;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_settle_cnt_nxt = r_settle_cnt;
        w_capture        = 1'b0;
        if (abort) begin
            w_state_nxt      = c_ST_IDLE;
            w_byte_cnt_nxt   = '0;
            w_settle_cnt_nxt = '0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_STREAM: begin
                    if (w_accept) begin
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            w_state_nxt      = c_ST_SETTLE;
                            w_byte_cnt_nxt   = '0;
                            w_settle_cnt_nxt = '0;
                        end else begin
                            w_state_nxt    = c_ST_STREAM;
                            w_byte_cnt_nxt = r_byte_cnt + c_BYTE_W'(1);
                        end
                    end
                end
                c_ST_SETTLE: begin
                    if (r_settle_cnt == c_LAST_SETTLE) begin
                        w_state_nxt      = c_ST_CAPTURE;
                        w_settle_cnt_nxt = '0;
                    end else begin
                        w_settle_cnt_nxt = r_settle_cnt + c_SETTLE_W'(1);
                    end
                end
                c_ST_CAPTURE: begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
                default: begin
                    w_state_nxt      = c_ST_IDLE;
                    w_byte_cnt_nxt   = '0;
                    w_settle_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_byte_cnt   <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
        end
    end

    // core_ui holds the last byte between strobes; an in-flight strobe survives abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_ui   <= '0;
            r_core_load <= 1'b0;
            r_res_index <= '0;
            r_res_value <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_core_load <= w_accept;
            if (w_accept) begin
                r_core_ui <= s_data;
            end
            r_res_valid <= w_capture;
            if (w_capture) begin
                r_res_index <= core_index;
                r_res_value <= core_value;
            end
        end
    end

    assign core_ui   = r_core_ui;
    assign core_load = r_core_load;
    assign res_index = r_res_index;
    assign res_value = r_res_value;
    assign res_valid = r_res_valid;

endmodule
`default_nettype wire

// File: tb/tb_lgn_frame_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lgn_frame_streamer                                                    |
// | Two streamers (98/16 and 2/1) driven in parallel against a frame model.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lgn_frame_streamer;

    localparam int BPF0 = 98;
    localparam int SET0 = 16;
    localparam int BPF1 = 2;
    localparam int SET1 = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       abort;
    logic [3:0] core_index;
    logic [7:0] core_value;

    logic [1:0] s_rdy;
    logic [1:0] c_load;
    logic [1:0] r_vld;
    logic [1:0] bsy;
    logic [7:0] c_ui  [2];
    logic [3:0] r_idx [2];
    logic [7:0] r_val [2];

    always #5 clk = ~clk;

    lgn_frame_streamer #(.BYTES_PER_FRAME(BPF0), .SETTLE_CYCLES(SET0), .INDEX_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_rdy[0]),
        .abort(abort), .core_ui(c_ui[0]), .core_load(c_load[0]), .core_index(core_index),
        .core_value(core_value), .res_index(r_idx[0]), .res_value(r_val[0]),
        .res_valid(r_vld[0]), .busy(bsy[0]));

    lgn_frame_streamer #(.BYTES_PER_FRAME(BPF1), .SETTLE_CYCLES(SET1), .INDEX_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_rdy[1]),
        .abort(abort), .core_ui(c_ui[1]), .core_load(c_load[1]), .core_index(core_index),
        .core_value(core_value), .res_index(r_idx[1]), .res_value(r_val[1]),
        .res_valid(r_vld[1]), .busy(bsy[1]));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // frame model: bytes seen this frame, first edge a new byte may land, edge of the result capture
    int          bpf [2];
    int          stl [2];
    int          m_cnt [2];
    int          m_rdy_edge [2];
    int          m_res_edge [2];
    logic        e_rdy [2];
    logic        e_load [2];
    logic        e_rv [2];
    logic        e_busy [2];
    logic        obs_rdy [2];
    logic [7:0]  e_ui [2];
    logic [7:0]  e_rval [2];
    logic [3:0]  e_ri [2];
    logic [23:0] obs_vec [2];
    logic [23:0] exp_vec [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_rdy_edge[k] = 0; m_res_edge[k] = -1;
            e_load[k] = 1'b0; e_rv[k] = 1'b0; e_busy[k] = 1'b0;
            e_ui[k] = 8'h00; e_rval[k] = 8'h00; e_ri[k] = 4'h0;
        end
    endtask

    // one clock: drive, sample s_ready before the edge, advance model, sample outputs after
    task automatic step(input logic v, input logic [7:0] d, input logic a);
        logic acc;
        s_valid = v; s_data = d; abort = a;
        #1;
        for (int k = 0; k < 2; k++) begin
            e_rdy[k]   = !a && (cyc + 1 >= m_rdy_edge[k]);
            obs_rdy[k] = s_rdy[k];
        end
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            acc       = v && !a && (cyc >= m_rdy_edge[k]);
            e_load[k] = acc;
            if (acc) e_ui[k] = d;
            e_rv[k] = 1'b0;
            if (a && (m_cnt[k] > 0 || cyc < m_rdy_edge[k])) begin
                m_cnt[k] = 0; m_rdy_edge[k] = cyc + 1; m_res_edge[k] = -1;
            end else if (cyc == m_res_edge[k]) begin
                e_rv[k] = 1'b1; e_ri[k] = core_index; e_rval[k] = core_value;
            end
            if (acc) begin
                m_cnt[k]++;
                if (m_cnt[k] == bpf[k]) begin
                    m_cnt[k]      = 0;
                    m_rdy_edge[k] = cyc + stl[k] + 2;
                    m_res_edge[k] = cyc + stl[k] + 1;
                end
            end
            e_busy[k] = (m_cnt[k] > 0) || (cyc < m_rdy_edge[k] - 1);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            obs_vec[k] = {obs_rdy[k], bsy[k], c_load[k], c_ui[k], r_vld[k], r_idx[k], r_val[k]};
            exp_vec[k] = {e_rdy[k], e_busy[k], e_load[k], e_ui[k], e_rv[k], e_ri[k], e_rval[k]};
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; abort = 1'b0; s_data = 8'h00;
        core_index = 4'h0; core_value = 8'h00;
        model_reset();
        #3;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({c_load[k], c_ui[k], r_vld[k], r_idx[k], r_val[k], bsy[k]} !== 23'd0) begin
                n_err++;
                $display("FAIL reset dut%0d: got %h want 0", k,
                         {c_load[k], c_ui[k], r_vld[k], r_idx[k], r_val[k], bsy[k]});
            end
        end
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int last_edge, rv_edge, rv_cnt;
        core_index = 4'd7; core_value = 8'hA5;
        rv_edge = -1; rv_cnt = 0;
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < BPF0 + 25; i++) begin
            if (i < BPF0) step(1'b1, 8'(i), 1'b0);
            else          step(1'b0, 8'h00, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    n_err++;
                    $display("FAIL back_to_back dut%0d edge %0d: got %h want %h", k, cyc, obs_vec[k], exp_vec[k]);
                end
            end
            if (i < BPF0) begin
                n_vec++;
                if ({c_load[0], c_ui[0]} !== {1'b1, 8'(i)}) begin
                    n_err++;
                    $display("FAIL b2b_strobe byte %0d: got load=%b ui=%h want load=1 ui=%h", i, c_load[0], c_ui[0], 8'(i));
                end
                if (i == BPF0 - 1) last_edge = cyc;
            end
            if (r_vld[0]) begin rv_cnt++; rv_edge = cyc; end
        end
        n_vec++;
        if (rv_cnt != 1 || rv_edge - last_edge + 1 != SET0 + 2) begin
            n_err++;
            $display("FAIL b2b_latency: got %0d pulses at %0d cycles want 1 at %0d", rv_cnt, rv_edge - last_edge + 1, SET0 + 2);
        end
        n_vec++;
        if ({r_idx[0], r_val[0]} !== {4'd7, 8'hA5}) begin
            n_err++;
            $display("FAIL b2b_result: got %h/%h want 7/a5", r_idx[0], r_val[0]);
        end
    endtask

    task automatic test_gappy();
        logic [7:0] q[$];
        logic [7:0] d, exp_b;
        int strobes;
        strobes = 0;
        step(1'b0, 8'h00, 1'b1);
        for (int t = 0; t < 2 * BPF0 + 20; t++) begin
            d = 8'($urandom);
            if (t < 2 * BPF0 && t % 2 == 0) begin
                q.push_back(d);
                step(1'b1, d, 1'b0);
            end else begin
                step(1'b0, d, 1'b0);
            end
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    n_err++;
                    $display("FAIL gappy dut%0d edge %0d: got %h want %h", k, cyc, obs_vec[k], exp_vec[k]);
                end
            end
            if (c_load[0]) begin
                exp_b = (q.size() != 0) ? q.pop_front() : 8'hxx;
                strobes++;
                n_vec++;
                if (c_ui[0] !== exp_b) begin
                    n_err++;
                    $display("FAIL gappy_order strobe %0d: got %h want %h", strobes, c_ui[0], exp_b);
                end
            end
        end
        n_vec++;
        if (strobes != BPF0 || q.size() != 0) begin
            n_err++;
            $display("FAIL gappy_count: got %0d strobes want %0d", strobes, BPF0);
        end
    endtask

    task automatic test_abort();
        logic [3:0] ni;
        logic [7:0] nv;
        int rv_cnt;
        step(1'b0, 8'h00, 1'b1);
        ni = 4'($urandom_range(8, 15)); nv = 8'($urandom_range(0, 160));
        core_index = ni; core_value = nv;
        for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'h3C, 1'b1);
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (obs_vec[k] !== exp_vec[k]) begin
                n_err++;
                $display("FAIL abort_edge dut%0d: got %h want %h", k, obs_vec[k], exp_vec[k]);
            end
        end
        n_vec++;
        if ({bsy[0], c_load[0]} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_idle: got busy=%b load=%b want 0/0", bsy[0], c_load[0]);
        end
        rv_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (r_vld[0]) rv_cnt++;
        end
        n_vec++;
        if (rv_cnt != 0 || {r_idx[0], r_val[0]} !== {4'd7, 8'hA5}) begin
            n_err++;
            $display("FAIL abort_hold: got %0d pulses res %h/%h want 0 pulses res 7/a5", rv_cnt, r_idx[0], r_val[0]);
        end
        for (int i = 0; i < BPF0 + 20; i++) begin
            if (i < BPF0) step(1'b1, 8'($urandom), 1'b0);
            else          step(1'b0, 8'h00, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    n_err++;
                    $display("FAIL abort_refill dut%0d edge %0d: got %h want %h", k, cyc, obs_vec[k], exp_vec[k]);
                end
            end
        end
        n_vec++;
        if ({r_idx[0], r_val[0]} !== {ni, nv}) begin
            n_err++;
            $display("FAIL abort_newres: got %h/%h want %h/%h", r_idx[0], r_val[0], ni, nv);
        end
    endtask

    task automatic test_hold_valid();
        int rv_t, extra;
        rv_t = -1; extra = 0;
        step(1'b0, 8'h00, 1'b1);
        for (int t = 0; t < BPF0 + SET0 + 4; t++) begin
            step(1'b1, 8'($urandom), 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    n_err++;
                    $display("FAIL hold_valid dut%0d edge %0d: got %h want %h", k, cyc, obs_vec[k], exp_vec[k]);
                end
            end
            if (t >= BPF0 && rv_t < 0 && (c_load[0] || obs_rdy[0])) extra++;
            if (rv_t >= 0 && t == rv_t + 1) begin
                n_vec++;
                if (c_load[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL hold_restart: got load=%b want 1", c_load[0]);
                end
            end
            if (r_vld[0] && rv_t < 0) rv_t = t;
        end
        n_vec++;
        if (extra != 0 || rv_t != BPF0 - 1 + SET0 + 1) begin
            n_err++;
            $display("FAIL hold_settle: got %0d stray strobes/ready, res at %0d want 0 and %0d", extra, rv_t, BPF0 + SET0);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid_settle();
        int rv_cnt;
        rv_cnt = 0;
        core_index = 4'hB; core_value = 8'h5E;
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < BPF0; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({c_load[k], c_ui[k], r_vld[k], r_idx[k], r_val[k], bsy[k]} !== 23'd0) begin
                n_err++;
                $display("FAIL async_reset dut%0d: got %h want 0", k,
                         {c_load[k], c_ui[k], r_vld[k], r_idx[k], r_val[k], bsy[k]});
            end
        end
        model_reset();
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < BPF0 + 20; i++) begin
            if (i < BPF0) step(1'b1, 8'($urandom), 1'b0);
            else          step(1'b0, 8'h00, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    n_err++;
                    $display("FAIL post_reset dut%0d edge %0d: got %h want %h", k, cyc, obs_vec[k], exp_vec[k]);
                end
            end
            if (r_vld[0]) rv_cnt++;
        end
        n_vec++;
        if (rv_cnt != 1 || {r_idx[0], r_val[0]} !== {4'hB, 8'h5E}) begin
            n_err++;
            $display("FAIL post_reset_frame: got %0d pulses res %h/%h want 1 pulse res b/5e", rv_cnt, r_idx[0], r_val[0]);
        end
    endtask

    task automatic test_small_frame();
        logic [1:0] rv_seq;
        core_index = 4'hC; core_value = 8'h81;
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        rv_seq[1] = r_vld[1];
        step(1'b0, 8'h00, 1'b0);
        rv_seq[0] = r_vld[1];
        n_vec++;
        if ({rv_seq, r_idx[1], r_val[1]} !== {2'b01, 4'hC, 8'h81}) begin
            n_err++;
            $display("FAIL small_latency: got rv=%b res %h/%h want rv=01 res c/81", rv_seq, r_idx[1], r_val[1]);
        end
        core_index = 4'h2; core_value = 8'h33;
        step(1'b1, 8'h44, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        rv_seq[1] = r_vld[1];
        step(1'b0, 8'h00, 1'b0);
        rv_seq[0] = r_vld[1];
        n_vec++;
        if ({rv_seq, r_idx[1], r_val[1], bsy[1]} !== {2'b00, 4'hC, 8'h81, 1'b0}) begin
            n_err++;
            $display("FAIL small_abort_capture: got rv=%b res %h/%h busy=%b want rv=00 res c/81 busy=0",
                     rv_seq, r_idx[1], r_val[1], bsy[1]);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            core_index = 4'($urandom);
            core_value = 8'($urandom);
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 99) < 3));
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    n_err++;
                    $display("FAIL random dut%0d edge %0d: got %h want %h", k, cyc, obs_vec[k], exp_vec[k]);
                end
            end
        end
    endtask

    initial begin
        bpf[0] = BPF0; stl[0] = SET0;
        bpf[1] = BPF1; stl[1] = SET1;
        test_reset();
        test_back_to_back();
        test_gappy();
        test_abort();
        test_hold_valid();
        test_reset_mid_settle();
        test_small_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
